// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types and constants for the QSPI transaction engine
//
// Purpose: target and state enumerations, QSPI command opcodes, and the
//          decode of requests that produce no bus activity.
// Ports:   none (package).
package qspi_pkg;

  typedef enum logic [1:0] {
    FLASH = 2'd0,
    RAM_A = 2'd1,
    RAM_B = 2'd2,
    NONE  = 2'd3
  } qspi_target_e;

  localparam logic [7:0] CMD_READ  = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE,
    ST_HOLD,
    ST_GAP
  } qspi_state_e;

  // Flash is read-only and NONE has no device: both complete without a frame.
  function automatic logic is_skip(input logic write, input qspi_target_e target);
    return (target == NONE) || ((target == FLASH) && write);
  endfunction

endpackage

// File: rtl/qspi_if.sv
// rtl/qspi_if.sv - request/response handshake between mem and the QSPI engine
//
// Purpose: one byte request (valid/ready) and a one-cycle response pulse.
// Signals: req_valid, req_ready, req_write, req_target, req_addr[23:0],
//          req_wdata[7:0], rsp_valid, rsp_rdata[7:0].
// Modports: master (requester), slave (engine).
interface qspi_if;
  import qspi_pkg::*;

  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  qspi_target_e req_target;
  logic [23:0]  req_addr;
  logic [7:0]   req_wdata;
  logic         rsp_valid;
  logic [7:0]   rsp_rdata;

  modport master (
    output req_valid, req_write, req_target, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_target, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/qspi_nibble_shifter.sv
// rtl/qspi_nibble_shifter.sv - 32-bit nibble shift register with phase counter
//
// Purpose: holds outgoing nibbles (MSB first) and collects incoming ones at the
//          LSB end; a down-counter marks the last nibble of the current phase.
// Ports:   clock, reset (sync, active-high); load, load_data[31:0],
//          load_count[3:0] (nibbles minus one); shift, capture_in[3:0];
//          nibble_out[3:0] (current outgoing nibble), low_nibble[3:0]
//          (most recently captured nibble), count[3:0], last.
module qspi_nibble_shifter (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [3:0]  load_count,
  input  logic        shift,
  input  logic [3:0]  capture_in,
  output logic [3:0]  nibble_out,
  output logic [3:0]  low_nibble,
  output logic [3:0]  count,
  output logic        last
);

  logic [31:0] sreg;
  logic [3:0]  cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg <= 32'h0;
      cnt  <= 4'h0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= load_count;
    end else if (shift) begin
      sreg <= {sreg[27:0], capture_in};
      cnt  <= cnt - 4'd1;
    end
  end

  assign nibble_out = sreg[31:28];
  assign low_nibble = sreg[3:0];
  assign count      = cnt;
  assign last       = (cnt == 4'd0);

endmodule

// File: rtl/qspi_engine.sv
// rtl/qspi_engine.sv - quad-SPI frame engine for flash / RAM A / RAM B
//
// Purpose: turns one byte request into a QSPI frame (cmd, 24-bit addr, dummy,
//          data), all quad, nibble MSB first, two system cycles per nibble.
// Ports:   clock, reset (sync, active-high); bus (qspi_if.slave);
//          spi_data_in[3:0], spi_data_out[3:0], spi_data_oe[3:0],
//          spi_clk_out, spi_flash_select, spi_ram_a_select, spi_ram_b_select
//          (selects active-low).
// Option:  QSPI_CONT_READ_EN keeps the device selected after a read so a read of
//          the next address goes straight to the data phase.
module qspi_engine
  import qspi_pkg::*;
#(
  parameter int FLASH_DUMMY = 4,
  parameter int RAM_DUMMY   = 6
) (
  input  logic       clock,
  input  logic       reset,
  qspi_if.slave      bus,
  input  logic [3:0] spi_data_in,
  output logic [3:0] spi_data_out,
  output logic [3:0] spi_data_oe,
  output logic       spi_clk_out,
  output logic       spi_flash_select,
  output logic       spi_ram_a_select,
  output logic       spi_ram_b_select
);

`ifdef QSPI_CONT_READ_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  qspi_state_e  state, state_next;
  logic         half;  // 0: cycle A (clk low, data changes), 1: cycle B (clk high)
  logic         lat_write, lat_skip;
  qspi_target_e lat_target;
  logic [23:0]  lat_addr;
  logic [7:0]   lat_wdata;
  logic [7:0]   rdata_q;

  logic         accept, req_skip, cont_hit, hold_pending;
  logic         active, sel_low, oe_bit;
  logic         sh_load, sh_shift, sh_last;
  logic [31:0]  sh_load_data;
  logic [3:0]   sh_load_count, sh_count, sh_nibble, sh_low, dummy_last;

  qspi_nibble_shifter u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load       (sh_load),
    .load_data  (sh_load_data),
    .load_count (sh_load_count),
    .shift      (sh_shift),
    .capture_in (spi_data_in),
    .nibble_out (sh_nibble),
    .low_nibble (sh_low),
    .count      (sh_count),
    .last       (sh_last)
  );

  assign bus.req_ready = (state == ST_IDLE) || (state == ST_HOLD);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_skip      = is_skip(bus.req_write, bus.req_target);

  // Sequential read continuation: same device, next byte, no 24-bit wrap.
  assign cont_hit = CONT_EN && (state == ST_HOLD) && !bus.req_write &&
                    (bus.req_target == lat_target) && (lat_addr != 24'hFFFFFF) &&
                    (bus.req_addr == lat_addr + 24'd1);
  assign hold_pending = CONT_EN && !lat_write && !lat_skip;
  assign dummy_last   = (lat_target == FLASH) ? 4'(FLASH_DUMMY - 1) : 4'(RAM_DUMMY - 1);

  always_comb begin
    state_next    = state;
    sh_load       = 1'b0;
    sh_shift      = 1'b0;
    sh_load_data  = 32'h0;
    sh_load_count = 4'h0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (cont_hit) begin
            sh_load       = 1'b1;
            sh_load_count = 4'd1;
            state_next    = ST_DATA;
          end else if (req_skip) begin
            state_next = ST_DONE;
          end else begin
            // cmd and addr are exactly 8 nibbles: one load covers both phases
            sh_load       = 1'b1;
            sh_load_data  = {(bus.req_write ? CMD_WRITE : CMD_READ), bus.req_addr};
            sh_load_count = 4'd7;
            // leaving HOLD for a new frame needs one deselected cycle first
            state_next    = (state == ST_HOLD) ? ST_GAP : ST_CMD;
          end
        end
      end
      ST_GAP: state_next = ST_CMD;
      ST_CMD: begin
        if (half) begin
          sh_shift = 1'b1;
          if (sh_count == 4'd6) state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (half) begin
          if (sh_last) begin
            sh_load = 1'b1;
            if (lat_write) begin
              sh_load_data  = {lat_wdata, 24'h0};
              sh_load_count = 4'd1;
              state_next    = ST_DATA;
            end else begin
              sh_load_count = dummy_last;
              state_next    = ST_DUMMY;
            end
          end else begin
            sh_shift = 1'b1;
          end
        end
      end
      ST_DUMMY: begin
        if (half) begin
          if (sh_last) begin
            sh_load       = 1'b1;
            sh_load_count = 4'd1;
            state_next    = ST_DATA;
          end else begin
            sh_shift = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (half) begin
          sh_shift = 1'b1;
          if (sh_last) state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = hold_pending ? ST_HOLD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      half       <= 1'b0;
      lat_write  <= 1'b0;
      lat_skip   <= 1'b0;
      lat_target <= NONE;
      lat_addr   <= 24'h0;
      lat_wdata  <= 8'h0;
      rdata_q    <= 8'h0;
    end else begin
      state <= state_next;
      half  <= active && !half;
      if (accept) begin
        lat_write  <= bus.req_write;
        lat_skip   <= req_skip;
        lat_target <= bus.req_target;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
      end
      // low nibble arrives on the same edge that enters DONE
      if ((state == ST_DATA) && half && sh_last && !lat_write)
        rdata_q <= {sh_low, spi_data_in};
    end
  end

  assign active  = (state == ST_CMD) || (state == ST_ADDR) ||
                   (state == ST_DUMMY) || (state == ST_DATA);
  assign sel_low = active || (state == ST_HOLD) || ((state == ST_DONE) && hold_pending);
  assign oe_bit  = (state == ST_CMD) || (state == ST_ADDR) || ((state == ST_DATA) && lat_write);

  assign spi_clk_out      = active && half;
  assign spi_data_oe      = {4{oe_bit}};
  assign spi_data_out     = oe_bit ? sh_nibble : 4'h0;
  assign spi_flash_select = !(sel_low && (lat_target == FLASH));
  assign spi_ram_a_select = !(sel_low && (lat_target == RAM_A));
  assign spi_ram_b_select = !(sel_low && (lat_target == RAM_B));

  assign bus.rsp_valid = (state == ST_DONE);
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_qspi_engine.sv
// tb/tb_qspi_engine.sv - scoreboard bench for qspi_engine with a QSPI device model
module tb_qspi_engine;
  import qspi_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       img_load;
  logic [3:0] spi_data_in, spi_data_out, spi_data_oe;
  logic       spi_clk_out, spi_flash_select, spi_ram_a_select, spi_ram_b_select;

  qspi_if bus ();

  qspi_engine dut (
    .clock            (clock),
    .reset            (reset),
    .bus              (bus),
    .spi_data_in      (spi_data_in),
    .spi_data_out     (spi_data_out),
    .spi_data_oe      (spi_data_oe),
    .spi_clk_out      (spi_clk_out),
    .spi_flash_select (spi_flash_select),
    .spi_ram_a_select (spi_ram_a_select),
    .spi_ram_b_select (spi_ram_b_select)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- device model (flash + two RAMs) ----------------
  logic [7:0]  mem_f [0:4095];
  logic [7:0]  mem_a [0:4095];
  logic [7:0]  mem_b [0:4095];
  logic [1:0]  dev;
  int          nib;
  logic [31:0] m_hdr;
  logic [3:0]  m_wnib;
  int          dj;
  logic [11:0] ra;
  logic [7:0]  rb;

  always_comb begin
    dev = 2'd3;
    if (!spi_flash_select)      dev = 2'd0;
    else if (!spi_ram_a_select) dev = 2'd1;
    else if (!spi_ram_b_select) dev = 2'd2;
  end

  always @(posedge clock) begin
    if (img_load) begin
      for (int i = 0; i < 4096; i++) begin
        mem_f[i] <= 8'h0; mem_a[i] <= 8'h0; mem_b[i] <= 8'h0;
      end
      mem_f[16] <= 8'hA5;
      mem_f[17] <= 8'h5A;
      mem_f[32] <= 8'hC3;
      nib    <= 0;
      m_hdr  <= 32'h0;
      m_wnib <= 4'h0;
    end else if (dev == 2'd3) begin
      nib <= 0;
    end else if (spi_clk_out) begin
      nib <= nib + 1;
      if (nib < 8) m_hdr <= {m_hdr[27:0], spi_data_out};
      else if (m_hdr[31:24] == 8'h38) begin
        if (nib == 8) m_wnib <= spi_data_out;
        else if (nib == 9) begin
          if (dev == 2'd1) mem_a[m_hdr[11:0]] <= {m_wnib, spi_data_out};
          if (dev == 2'd2) mem_b[m_hdr[11:0]] <= {m_wnib, spi_data_out};
        end
      end
    end
  end

  always_comb begin
    spi_data_in = 4'h0;
    dj = 0;
    ra = 12'h0;
    rb = 8'h0;
    if ((dev != 2'd3) && (nib >= 8) && (m_hdr[31:24] == 8'hEB)) begin
      dj = nib - 8 - ((dev == 2'd0) ? 4 : 6);
      if (dj >= 0) begin
        ra = m_hdr[11:0] + 12'(dj / 2);
        rb = (dev == 2'd0) ? mem_f[ra] : (dev == 2'd1) ? mem_a[ra] : mem_b[ra];
        spi_data_in = dj[0] ? rb[3:0] : rb[7:4];
      end
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    int acc;
    int cyc_exp;
    int rdata;
    int sel;
    int oe;
    int clk;
    int mask;
  } exp_t;

  exp_t sb[$];
  int sel_cnt = 0, oe_cnt = 0, clk_cnt = 0, sel_mask = 0;
  int sel_fall = 0, rdy_in_frame = 0;
  bit prev_low = 1'b0;

  always @(negedge clock) begin
    bit any_low;
    exp_t e;
    any_low = !spi_flash_select || !spi_ram_a_select || !spi_ram_b_select;
    if (reset) begin
      sel_cnt = 0; oe_cnt = 0; clk_cnt = 0; sel_mask = 0;
    end else begin
      if (any_low) sel_cnt++;
      if (spi_data_oe != 4'h0) oe_cnt++;
      if (spi_clk_out) clk_cnt++;
      if (!spi_flash_select) sel_mask = sel_mask | 1;
      if (!spi_ram_a_select) sel_mask = sel_mask | 2;
      if (!spi_ram_b_select) sel_mask = sel_mask | 4;
      if (any_low && !prev_low) sel_fall++;
      if (any_low && bus.req_ready) rdy_in_frame++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", cyc - e.acc + 1, e.cyc_exp);
          if (e.rdata >= 0) check("rsp_rdata", bus.rsp_rdata, e.rdata);
          if (e.sel >= 0) begin
            check("sel_low_cycles", sel_cnt, e.sel);
            check("oe_cycles", oe_cnt, e.oe);
            check("clk_high_cycles", clk_cnt, e.clk);
            check("sel_mask", sel_mask, e.mask);
          end
        end
        sel_cnt = 0; oe_cnt = 0; clk_cnt = 0; sel_mask = 0;
      end
    end
    prev_low = any_low;
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic issue(input logic wr, input qspi_target_e tg, input logic [23:0] a,
                       input logic [7:0] d, input int cexp, input int rexp, input int s,
                       input int o, input int c, input int m, input bit keep, input bit push);
    int n = 0;
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_target = tg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    while (!bus.req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      e.acc = cyc; e.cyc_exp = cexp; e.rdata = rexp;
      e.sel = s; e.oe = o; e.clk = c; e.mask = m;
      if (push) sb.push_back(e);
      if (!keep) bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, r0;
    reset = 1'b1; img_load = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_target = NONE;
    bus.req_addr = 24'h0; bus.req_wdata = 8'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; img_load = 1'b0;
    @(negedge clock);
    check("rst_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    check("rst_selects", {spi_flash_select, spi_ram_a_select, spi_ram_b_select}, 3'b111);
    check("rst_clk_oe_out", {spi_clk_out, spi_data_oe, spi_data_out}, 0);

`ifdef QSPI_CONT_READ_EN
    f0 = sel_fall;
    issue(1'b0, FLASH, 24'h000010, 8'h00, 29, 8'hA5, -1, -1, -1, -1, 1'b0, 1'b1); wait_idle();
    issue(1'b0, FLASH, 24'h000011, 8'h00, 5, 8'h5A, -1, -1, -1, -1, 1'b0, 1'b1); wait_idle();
    check("cont_select_falls", sel_fall - f0, 1);
    check("cont_hold_select", spi_flash_select, 0);
    check("cont_hold_ready", bus.req_ready, 1);
    issue(1'b0, FLASH, 24'h000020, 8'h00, 30, 8'hC3, -1, -1, -1, -1, 1'b0, 1'b1); wait_idle();
    check("cont_new_frame_falls", sel_fall - f0, 2);
    check("cont_new_hdr", m_hdr, 32'hEB000020);
    issue(1'b1, RAM_A, 24'h000100, 8'h3C, 22, 8'hC3, -1, -1, -1, -1, 1'b0, 1'b1); wait_idle();
    check("cont_write_ends_hold", {spi_flash_select, spi_ram_a_select, spi_ram_b_select}, 3'b111);
    issue(1'b0, RAM_A, 24'h000100, 8'h00, 33, 8'h3C, -1, -1, -1, -1, 1'b0, 1'b1); wait_idle();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("cont_reset_ends_hold", {spi_flash_select, spi_ram_a_select, spi_ram_b_select}, 3'b111);
`else
    issue(1'b0, FLASH, 24'h000010, 8'h00, 29, 8'hA5, 28, 16, 14, 1, 1'b0, 1'b1); wait_idle();
    check("flash_read_hdr", m_hdr, 32'hEB000010);
    issue(1'b1, RAM_A, 24'h000100, 8'h3C, 21, 8'hA5, 20, 20, 10, 2, 1'b0, 1'b1); wait_idle();
    check("ram_write_hdr", m_hdr, 32'h38000100);
    issue(1'b0, RAM_A, 24'h000100, 8'h00, 33, 8'h3C, 32, 16, 16, 2, 1'b0, 1'b1); wait_idle();
    issue(1'b1, FLASH, 24'h000010, 8'hFF, 1, 8'h3C, 0, 0, 0, 0, 1'b0, 1'b1); wait_idle();
    issue(1'b0, NONE, 24'h000010, 8'h00, 1, 8'h3C, 0, 0, 0, 0, 1'b0, 1'b1); wait_idle();

    f0 = sel_fall; r0 = rdy_in_frame;
    issue(1'b1, RAM_B, 24'h000005, 8'h77, 21, 8'h3C, 20, 20, 10, 4, 1'b1, 1'b1);
    issue(1'b1, RAM_A, 24'h000101, 8'h99, 21, 8'h3C, 20, 20, 10, 2, 1'b0, 1'b1); wait_idle();
    check("b2b_select_falls", sel_fall - f0, 2);
    check("b2b_ready_in_frame", rdy_in_frame - r0, 0);

    issue(1'b0, RAM_B, 24'h000005, 8'h00, 33, 8'h77, 32, 16, 16, 4, 1'b0, 1'b1);
    wait_idle();
    issue(1'b0, RAM_A, 24'h000101, 8'h00, 33, 8'h99, 32, 16, 16, 2, 1'b0, 1'b1);
    bus.req_target = FLASH; bus.req_addr = 24'h000010; bus.req_write = 1'b1;
    wait_idle();

    issue(1'b0, RAM_B, 24'h000005, 8'h00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    repeat (8) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_selects", {spi_flash_select, spi_ram_a_select, spi_ram_b_select}, 3'b111);
    check("abort_clk", spi_clk_out, 0);
    check("abort_oe", spi_data_oe, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_ready", bus.req_ready, 1);
    check("abort_rdata", bus.rsp_rdata, 0);
    repeat (30) @(negedge clock);
    issue(1'b0, RAM_B, 24'h000005, 8'h00, 33, 8'h77, 32, 16, 16, 4, 1'b0, 1'b1); wait_idle();
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
